// File: rtl/hazard_stall_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit_pkg
// Shared definitions for the hazard/forwarding block and the datapath operand
// muxes that consume its forward selects.
//   mem_state_t : data-memory wait FSM encoding (IDLE / WAIT / HALT)
//   FWD_*       : E-stage operand select codes
//   reg_match   : register-number compare where $0 never matches
// ----------------------------------------------------------------------------
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } mem_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from M-stage ALU result

  // $0 is hard-wired to zero, so a producer writing it never creates a
  // dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_forward_unit.sv
// ----------------------------------------------------------------------------
// forward_unit
// Purely combinational operand forwarding for the E-stage ALU and the D-stage
// branch comparator.
//   rs_d, rt_d       : D-stage source registers
//   rs_e, rt_e       : E-stage source registers
//   writereg_m/_w    : destination registers in M / W
//   regwrite_m/_w    : write enables in M / W
//   forwarda_e/b_e   : E operand select (FWD_RF / FWD_W / FWD_M)
//   forwarda_d/b_d   : D comparator operand taken from M
// ----------------------------------------------------------------------------
module forward_unit
  import hazard_stall_unit_pkg::*;
(
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] writereg_m,
  input  logic [4:0] writereg_w,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  output logic [1:0] forwarda_e,
  output logic [1:0] forwardb_e,
  output logic       forwarda_d,
  output logic       forwardb_d
);

  // M is the younger producer, so it wins over W.
  always_comb begin
    forwarda_e = FWD_RF;
    if (regwrite_m && reg_match(rs_e, writereg_m))
      forwarda_e = FWD_M;
    else if (regwrite_w && reg_match(rs_e, writereg_w))
      forwarda_e = FWD_W;
  end

  always_comb begin
    forwardb_e = FWD_RF;
    if (regwrite_m && reg_match(rt_e, writereg_m))
      forwardb_e = FWD_M;
    else if (regwrite_w && reg_match(rt_e, writereg_w))
      forwardb_e = FWD_W;
  end

  assign forwarda_d = regwrite_m && reg_match(rs_d, writereg_m);
  assign forwardb_d = regwrite_m && reg_match(rt_d, writereg_m);

endmodule

// File: rtl/hazard_stall_unit.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit
// Hazard detection and forwarding for the 5-stage MIPS pipeline, with a
// data-memory wait FSM (timeout -> sticky error and permanent halt) and a
// saturating counter of fetch-stall cycles.
//   clk, reset          : clock, asynchronous active-low reset
//   rs_*/rt_*/writereg_*: register numbers per stage
//   regwrite_*, memtoreg_*, memwrite_m, branch_d, pcsrc_d : stage controls
//   dmem_ready          : data memory finishes the M access this cycle
//   stallf..stallw      : hold pipeline registers
//   flushd, flushe      : clear IF-ID / bubble ID-EX
//   forward*            : operand forwarding selects
//   mem_err             : sticky memory-timeout flag
//   stall_cnt           : saturating count of cycles with stallf=1
// ----------------------------------------------------------------------------
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       writereg_e,
  input  logic [4:0]       writereg_m,
  input  logic [4:0]       writereg_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             memtoreg_e,
  input  logic             memtoreg_m,
  input  logic             memwrite_m,
  input  logic             branch_d,
  input  logic             pcsrc_d,
  input  logic             dmem_ready,
  output logic             stallf,
  output logic             stalld,
  output logic             flushd,
  output logic             stalle,
  output logic             stallm,
  output logic             stallw,
  output logic             flushe,
  output logic [1:0]       forwarda_e,
  output logic [1:0]       forwardb_e,
  output logic             forwarda_d,
  output logic             forwardb_d,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  forward_unit u_forward (
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .rs_e       (rs_e),
    .rt_e       (rt_e),
    .writereg_m (writereg_m),
    .writereg_w (writereg_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .forwarda_e (forwarda_e),
    .forwardb_e (forwardb_e),
    .forwarda_d (forwarda_d),
    .forwardb_d (forwardb_d)
  );

  // --------------------------------------------------------------------------
  // Pipeline hazards detected in D
  // --------------------------------------------------------------------------
  logic lwstall;
  logic brstall;
  logic mem_access_m;

  assign lwstall = memtoreg_e && (reg_match(rs_d, rt_e) || reg_match(rt_d, rt_e));

  // A branch resolved in D needs its operands now: an ALU result still in E,
  // or load data not yet back from M, cannot be forwarded in time.
  assign brstall = branch_d &&
                   ((regwrite_e && (reg_match(rs_d, writereg_e) || reg_match(rt_d, writereg_e))) ||
                    (memtoreg_m && (reg_match(rs_d, writereg_m) || reg_match(rt_d, writereg_m))));

  assign mem_access_m = memtoreg_m || memwrite_m;

  // --------------------------------------------------------------------------
  // Data-memory wait FSM
  // --------------------------------------------------------------------------
  mem_state_t       state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             mem_err_reg, mem_err_next;
  logic             memstall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      mem_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      mem_err_reg <= mem_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    mem_err_next = mem_err_reg;
    case (state_reg)
      IDLE: begin
        if (mem_access_m && !dmem_ready) begin
          state_next = WAIT;
          timer_next = TMR_W'(1);  // the IDLE cycle already counted as one
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (timer_reg == TMR_LAST) begin
          state_next   = HALT;
          mem_err_next = 1'b1;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      HALT: ;  // only reset leaves HALT
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_comb begin
    memstall = 1'b0;
    case (state_reg)
      IDLE:    memstall = mem_access_m && !dmem_ready;
      WAIT:    memstall = !dmem_ready;  // released in the ready cycle itself
      HALT:    memstall = 1'b1;
      default: memstall = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Stall / flush outputs; a memory stall freezes the whole pipe and masks
  // the D-stage hazards, whose bubbles would otherwise be lost.
  // --------------------------------------------------------------------------
  always_comb begin
    stallf = 1'b0;
    stalld = 1'b0;
    flushd = 1'b0;
    stalle = 1'b0;
    stallm = 1'b0;
    stallw = 1'b0;
    flushe = 1'b0;
    if (!reset) begin
      // all stall/flush outputs held low during reset
    end else if (memstall) begin
      stallf = 1'b1;
      stalld = 1'b1;
      stalle = 1'b1;
      stallm = 1'b1;
      stallw = 1'b1;
    end else begin
      stallf = lwstall || brstall;
      stalld = lwstall || brstall;
      flushe = lwstall || brstall;
      flushd = pcsrc_d && !(lwstall || brstall);
    end
  end

  // --------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_reg <= '0;
    else if (stallf && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
  end

  assign mem_err   = mem_err_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic       clk;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] writereg_e, writereg_m, writereg_w;
  logic       regwrite_e, regwrite_m, regwrite_w;
  logic       memtoreg_e, memtoreg_m, memwrite_m;
  logic       branch_d, pcsrc_d, dmem_ready;
  logic       stallf, stalld, flushd, stalle, stallm, stallw, flushe;
  logic [1:0] forwarda_e, forwardb_e;
  logic       forwarda_d, forwardb_d;
  logic       mem_err;
  logic [3:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  hazard_stall_unit #(
    .MEM_TIMEOUT (4),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .rs_e       (rs_e),
    .rt_e       (rt_e),
    .writereg_e (writereg_e),
    .writereg_m (writereg_m),
    .writereg_w (writereg_w),
    .regwrite_e (regwrite_e),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .memtoreg_e (memtoreg_e),
    .memtoreg_m (memtoreg_m),
    .memwrite_m (memwrite_m),
    .branch_d   (branch_d),
    .pcsrc_d    (pcsrc_d),
    .dmem_ready (dmem_ready),
    .stallf     (stallf),
    .stalld     (stalld),
    .flushd     (flushd),
    .stalle     (stalle),
    .stallm     (stallm),
    .stallw     (stallw),
    .flushe     (flushe),
    .forwarda_e (forwarda_e),
    .forwardb_e (forwardb_e),
    .forwarda_d (forwarda_d),
    .forwardb_d (forwardb_d),
    .mem_err    (mem_err),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // advance one clock edge, then settle before inputs/outputs are touched
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    writereg_e = 0; writereg_m = 0; writereg_w = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    memtoreg_e = 0; memtoreg_m = 0; memwrite_m = 0;
    branch_d = 0; pcsrc_d = 0; dmem_ready = 1;
  endtask

  // all five stalls packed {f,d,e,m,w}
  function automatic logic [4:0] stalls();
    return {stallf, stalld, stalle, stallm, stallw};
  endfunction

  initial begin
    clear_inputs();
    reset = 1'b0;
    #3;
    check("reset_stalls", {27'd0, stalls()}, 32'h00);
    check("reset_flush", {30'd0, flushd, flushe}, 32'h0);
    check("reset_cnt", {28'd0, stall_cnt}, 32'd0);
    check("reset_err", {31'd0, mem_err}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // ---------------- forwarding ----------------
    regwrite_m = 1; writereg_m = 5; rs_e = 5; regwrite_w = 1; writereg_w = 5;
    #1 check("fwda_e_m_prio", {30'd0, forwarda_e}, 32'h2);
    regwrite_m = 0;
    #1 check("fwda_e_w", {30'd0, forwarda_e}, 32'h1);
    writereg_w = 0; rs_e = 0;
    #1 check("fwda_e_rf", {30'd0, forwarda_e}, 32'h0);
    regwrite_m = 1; writereg_m = 0;
    #1 check("fwda_e_r0", {30'd0, forwarda_e}, 32'h0);
    rt_e = 7; regwrite_w = 1; writereg_w = 7; writereg_m = 3; rs_d = 3; rt_d = 4;
    #1 check("fwdb_e_w", {30'd0, forwardb_e}, 32'h1);
    check("fwd_d", {30'd0, forwarda_d, forwardb_d}, 32'h2);
    clear_inputs();
    tick();

    // ---------------- load-use ----------------
    memtoreg_e = 1; rt_e = 8; rs_d = 8;
    #1 check("lw_stalls", {27'd0, stalls()}, 32'h18);
    check("lw_flushe", {31'd0, flushe}, 32'd1);
    tick(); tick(); tick();
    check("lw_cnt3", {28'd0, stall_cnt}, 32'd3);
    clear_inputs();
    tick();
    check("lw_cnt_hold", {28'd0, stall_cnt}, 32'd3);

    // ---------------- branch ----------------
    branch_d = 1; regwrite_e = 1; writereg_e = 9; rt_d = 9; pcsrc_d = 1;
    #1 check("br_stalls", {27'd0, stalls()}, 32'h18);
    check("br_flush_masked", {30'd0, flushd, flushe}, 32'h1);
    tick();
    check("br_cnt4", {28'd0, stall_cnt}, 32'd4);
    regwrite_e = 0;
    #1 check("br_taken", {30'd0, flushd, stalld}, 32'h2);
    regwrite_e = 0; memtoreg_m = 1; writereg_m = 4; rs_d = 4; dmem_ready = 1;
    #1 check("br_load_m", {31'd0, stallf}, 32'd1);
    clear_inputs();
    #1 check("br_clear", {31'd0, stallf}, 32'd0);

    // ---------------- memory wait: 3 stalled cycles then ready ----------------
    memtoreg_m = 1; dmem_ready = 0;
    #1 check("mw_c1", {27'd0, stalls()}, 32'h1F);
    tick();
    check("mw_c2", {27'd0, stalls()}, 32'h1F);
    tick();
    check("mw_c3", {27'd0, stalls()}, 32'h1F);
    tick();
    dmem_ready = 1;
    #1 check("mw_ready", {27'd0, stalls()}, 32'h00);
    check("mw_cnt7", {28'd0, stall_cnt}, 32'd7);
    tick();
    check("mw_idle", {27'd0, stalls()}, 32'h00);
    check("mw_err", {31'd0, mem_err}, 32'd0);
    check("mw_cnt_hold", {28'd0, stall_cnt}, 32'd7);

    // ---------------- priority + timeout ----------------
    clear_inputs();
    memwrite_m = 1; dmem_ready = 0;
    memtoreg_e = 1; rt_e = 8; rs_d = 8; pcsrc_d = 1;
    #1 check("prio_stalls", {27'd0, stalls()}, 32'h1F);
    check("prio_flush", {30'd0, flushd, flushe}, 32'h0);
    tick(); tick(); tick();
    check("to_err_early", {31'd0, mem_err}, 32'd0);
    tick();
    check("to_err_set", {31'd0, mem_err}, 32'd1);
    check("to_cnt11", {28'd0, stall_cnt}, 32'd11);
    tick(); tick(); tick();
    dmem_ready = 1; memwrite_m = 0; memtoreg_e = 0;
    #1 check("halt_stalls", {27'd0, stalls()}, 32'h1F);
    check("halt_cnt14", {28'd0, stall_cnt}, 32'd14);

    // ---------------- asynchronous reset out of HALT ----------------
    reset = 1'b0;
    #1 check("ar_stalls", {27'd0, stalls()}, 32'h00);
    check("ar_err", {31'd0, mem_err}, 32'd0);
    check("ar_cnt", {28'd0, stall_cnt}, 32'd0);
    regwrite_m = 1; writereg_m = 6; rs_d = 6;
    #1 check("ar_fwd_d", {31'd0, forwarda_d}, 32'd1);
    tick();
    reset = 1'b1;
    clear_inputs();
    #1 check("rec_idle", {27'd0, stalls()}, 32'h00);

    // ---------------- saturation ----------------
    memwrite_m = 1; dmem_ready = 0;
    for (int i = 0; i < 17; i++) tick();
    check("sat_cnt", {28'd0, stall_cnt}, 32'd15);
    check("sat_err", {31'd0, mem_err}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Hazard-detection and forwarding block for the 5-stage MIPS pipeline.
- Sits directly upstream of the pipelined controller and datapath registers; produces the stall, flush and forward selects they consume.
- Adds a registered data-memory wait FSM with timeout, an error trap, and a saturating stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting on dmem_ready before trapping; must be ≥2.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- rs_d, rt_d  input  5  source registers in D.
- rs_e, rt_e  input  5  source registers in E.
- writereg_e, writereg_m, writereg_w  input  5  destination register per stage.
- regwrite_e, regwrite_m, regwrite_w  input  1  register-write enables per stage.
- memtoreg_e, memtoreg_m  input  1  load in E / M.
- memwrite_m  input  1  store in M.
- branch_d  input  1  branch in D.
- pcsrc_d  input  1  branch taken in D.
- dmem_ready  input  1  data memory completes the M access this cycle.
- stallf, stalld  output  1  hold PC / IF-ID register.
- flushd  output  1  clear IF-ID register.
- stalle, stallm, stallw  output  1  hold ID-EX / EX-MEM / MEM-WB control and data.
- flushe  output  1  bubble into ID-EX.
- forwarda_e, forwardb_e  output  2  E operand select: 00 regfile, 01 W result, 10 M ALU result.
- forwarda_d, forwardb_d  output  1  D branch-comparator operand from M.
- mem_err  output  1  sticky memory-timeout flag.
- stall_cnt  output  CNT_W  saturating count of cycles with stallf=1.

Behaviour:
- Register number 0 never matches for forwarding or hazard checks.
- Forwarding (combinational):
  - forwarda_e = 10 if regwrite_m and writereg_m==rs_e; else 01 if regwrite_w and writereg_w==rs_e; else 00. M has priority over W.
  - forwardb_e: same rule using rt_e.
  - forwarda_d = regwrite_m and writereg_m==rs_d; forwardb_d uses rt_d.
- Load-use stall: lwstall = memtoreg_e and (rt_e==rs_d or rt_e==rt_d).
- Branch stall: brstall = branch_d and ((regwrite_e and writereg_e∈{rs_d,rt_d}) or (memtoreg_m and writereg_m∈{rs_d,rt_d})).
- mem_access_m = memtoreg_m or memwrite_m.
- Mem FSM states IDLE, WAIT, HALT; registered state plus timer (ceil(log2 MEM_TIMEOUT) bits).
  - IDLE: memstall = mem_access_m and !dmem_ready. If memstall, go to WAIT with timer=1; else stay in IDLE.
  - WAIT: memstall = !dmem_ready.
    - dmem_ready=1: go to IDLE and clear timer; stalls release in that same cycle.
    - else if timer==MEM_TIMEOUT-1: set mem_err=1 and go to HALT.
    - else timer+1.
  - HALT: memstall=1 permanently. Only reset leaves HALT.
- Output priority:
  - memstall=1: stallf=stalld=stalle=stallm=stallw=1; flushd=flushe=0; load-use and branch stalls are masked.
  - Otherwise:
    - stallf = stalld = flushe = lwstall or brstall.
    - stalle = stallm = stallw = 0.
    - flushd = pcsrc_d and !stalld.
- stall_cnt: +1 on every clock edge with stallf=1; saturates at all-ones and does not wrap.
- Reset (reset=0), asynchronous, takes effect immediately:
  - state=IDLE, timer=0, mem_err=0, stall_cnt=0.
  - All stall and flush outputs are forced to 0; forwarding outputs stay combinational.
  - Reset mid-WAIT or in HALT fully recovers.
- Latency: all stall, flush and forward outputs are combinational from inputs and registered state, zero cycles. FSM and counter update on the clock edge.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, WAIT=2'd1, HALT=2'd2) and forward-select constants (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), reused by the datapath operand muxes.
- One natural sub-module, forward_unit: pure combinational forwarding for E and D, instantiated once. The stall logic, FSM and counter stay in hazard_stall_unit.

Test Plan:
- Forwarding: regwrite_m=1, writereg_m=5, rs_e=5; regwrite_w=1, writereg_w=5 -> forwarda_e=10. Then regwrite_m=0 -> forwarda_e=01. Then writereg_w=0, rs_e=0 -> forwarda_e=00.
- Load-use: memtoreg_e=1, rt_e=8, rs_d=8 -> stallf=stalld=flushe=1, stalle=0; stall_cnt rises by 1 per cycle held.
- Branch: branch_d=1, regwrite_e=1, writereg_e=9, rt_d=9 -> stall asserted. Next cycle the hazard clears and pcsrc_d=1 -> flushd=1, stalld=0.
- Memory wait: memtoreg_m=1, dmem_ready=0 for 3 cycles then 1 -> all five stalls high for exactly 3 cycles and low in the ready cycle. state returns to IDLE; mem_err=0.
- Timeout: MEM_TIMEOUT=4, memwrite_m=1, dmem_ready held at 0 -> mem_err=1 after 4 stalled cycles and stalls stay high indefinitely. Pulse reset low -> mem_err=0, stall_cnt=0, stalls drop immediately without a clock edge.
- Priority: memstall active together with lwstall and pcsrc_d=1 -> flushe=0, flushd=0, all stalls high.
